// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_GROUP_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Carry out of one lookahead group given its generate/propagate pair and carry in.
    function automatic logic group_carry(input gp_t gp, input logic cin);
        return gp.g | (gp.p & cin);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_GROUP_W-1:0] sum,
    output gp_t                    gp
);

    logic [CLA_GROUP_W-1:0] g;
    logic [CLA_GROUP_W-1:0] p;
    logic [CLA_GROUP_W-1:0] c;

    // Every internal carry is a flat sum of products of cin, g and p.
    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
        gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp.p = &p;
    end

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder with valid/ready streaming on both sides.
// Optional CLA_FLAGS_EN adds registered zero and signed-overflow outputs.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_ovf
`endif
);

    localparam int unsigned NG     = WIDTH / CLA_GROUP_W;
    localparam int unsigned SW     = CLA_GROUP_W * GROUPS_PER_STAGE;
    localparam int unsigned STAGES = NG / GROUPS_PER_STAGE;

    if (WIDTH == 0 || (WIDTH % CLA_GROUP_W) != 0) begin : g_bad_width
        $error("pipe_cla_adder: WIDTH must be a non-zero multiple of 4");
    end
    if (GROUPS_PER_STAGE == 0 || (NG % GROUPS_PER_STAGE) != 0) begin : g_bad_gps
        $error("pipe_cla_adder: WIDTH/4 must be divisible by GROUPS_PER_STAGE");
    end

    // xq carries operand A shifted down with finished sum bits entering from the top;
    // after the last stage it holds the complete sum. yq carries operand B shifted down.
    logic [WIDTH-1:0]  xq [STAGES];
    logic [WIDTH-1:0]  yq [STAGES];
    logic [STAGES-1:0] cq;
    logic [STAGES-1:0] vq;

    logic [WIDTH-1:0]  xa [STAGES];
    logic [WIDTH-1:0]  xb [STAGES];
    logic [WIDTH-1:0]  xn [STAGES];
    logic [WIDTH-1:0]  yn [STAGES];
    logic [STAGES-1:0] ci;
    logic [STAGES-1:0] co;
    logic [STAGES-1:0] vin;

    logic [WIDTH-1:0]  gsum;
    gp_t  [NG-1:0]     gp;
    logic [NG-1:0]     gc;
    logic              en;

    assign en       = !vq[STAGES-1] || out_ready;
    assign in_ready = en;

    always_comb begin
        xa[0]  = in_a;
        xb[0]  = in_b;
        ci[0]  = in_cin;
        vin[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            xa[k]  = xq[k-1];
            xb[k]  = yq[k-1];
            ci[k]  = cq[k-1];
            vin[k] = vq[k-1];
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        localparam int unsigned K = g / GROUPS_PER_STAGE;
        localparam int unsigned J = g % GROUPS_PER_STAGE;
        cla_group4 u_grp (
            .a   (xa[K][CLA_GROUP_W*J +: CLA_GROUP_W]),
            .b   (xb[K][CLA_GROUP_W*J +: CLA_GROUP_W]),
            .cin (gc[g]),
            .sum (gsum[CLA_GROUP_W*g +: CLA_GROUP_W]),
            .gp  (gp[g])
        );
    end

    always_comb begin
        gc = '0;
        co = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            for (int unsigned j = 0; j < GROUPS_PER_STAGE; j++) begin
                if (j == 0) begin
                    gc[k*GROUPS_PER_STAGE] = ci[k];
                end else begin
                    gc[k*GROUPS_PER_STAGE+j] = group_carry(gp[k*GROUPS_PER_STAGE+j-1],
                                                           gc[k*GROUPS_PER_STAGE+j-1]);
                end
            end
            co[k] = group_carry(gp[k*GROUPS_PER_STAGE+GROUPS_PER_STAGE-1],
                                gc[k*GROUPS_PER_STAGE+GROUPS_PER_STAGE-1]);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            xn[k] = (xa[k] >> SW) | (WIDTH'(gsum[SW*k +: SW]) << (WIDTH - SW));
            yn[k] = xb[k] >> SW;
        end
    end

`ifdef CLA_FLAGS_EN
    logic zero_d;
    logic ovf_d;
    logic zero_q;
    logic ovf_q;

    // Last stage sees the operand sign bits at the top of its own slice.
    assign zero_d = (xn[STAGES-1] == '0);
    assign ovf_d  = (xa[STAGES-1][SW-1] == xb[STAGES-1][SW-1]) &&
                    (gsum[WIDTH-1] != xa[STAGES-1][SW-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_zero = zero_q;
    assign out_ovf  = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                xq[k] <= '0;
                yq[k] <= '0;
            end
            cq <= '0;
            vq <= '0;
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                xq[k] <= xn[k];
                yq[k] <= yn[k];
            end
            cq <= co;
            vq <= vin;
        end
    end

    assign out_valid = vq[STAGES-1];
    assign out_sum   = xq[STAGES-1];
    assign out_cout  = cq[STAGES-1];

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16, one group per stage, four stages).
module tb_pipe_cla_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned LAT = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef CLA_FLAGS_EN
    logic         out_zero;
    logic         out_ovf;
`endif

    pipe_cla_adder #(
        .WIDTH            (W),
        .GROUPS_PER_STAGE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef CLA_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    bit   chk_lat = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t         e;
        logic [W:0]   t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.zero = (t[W-1:0] == '0);
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: observe handshakes just after the falling edge, score, then advance.
    task automatic cycle(output bit acc, output bit popped);
        exp_t e;
        #1;
        acc    = (in_valid === 1'b1) && (in_ready === 1'b1);
        popped = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (popped) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_beat observed=0x%0h expected=none", out_sum);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sum", 32'(out_sum), 32'(e.sum));
                chk("cout", 32'(out_cout), 32'(e.cout));
`ifdef CLA_FLAGS_EN
                chk("zero", 32'(out_zero), 32'(e.zero));
                chk("ovf", 32'(out_ovf), 32'(e.ovf));
`endif
                if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'(LAT));
            end
        end
        if (acc) begin
            pend.cyc = cyc;
            q.push_back(pend);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input exp_t e);
        bit acc;
        bit pop;
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        pend     = e;
        do begin
            cycle(acc, pop);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        send(a, b, c, model(a, b, c));
    endtask

    task automatic drain(input string tag);
        bit acc;
        bit pop;
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            cycle(acc, pop);
            n++;
        end
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        bit   acc;
        bit   pop;
        bit   pending;
        int   accepted;
        int   ncyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 0xFFFF + 0x0001: wrap to zero with carry out, exactly LAT cycles after accept
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        e         = model(16'hFFFF, 16'h0001, 1'b0);
        e.sum     = 16'h0000;
        e.cout    = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, e);
        in_valid = 1'b0;
        repeat (LAT - 1) begin
            #1;
            chk("lat_early", 32'(out_valid), 32'd0);
            cycle(acc, pop);
        end
        #1;
        chk("lat_on_time", 32'(out_valid), 32'd1);
        drain("drain_wrap");

        // Back-to-back beats emerge on consecutive cycles in order
        e = model(16'h0001, 16'h0001, 1'b0); e.sum = 16'h0002; e.cout = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, e);
        e = model(16'h1234, 16'h4321, 1'b0); e.sum = 16'h5555; e.cout = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, e);
        e = model(16'h00FF, 16'h0001, 1'b1); e.sum = 16'h0101; e.cout = 1'b0;
        send(16'h00FF, 16'h0001, 1'b1, e);
        drain("drain_b2b");

        // Fill the pipe with the consumer stalled, then release
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        send_m(16'h1111, 16'h2222, 1'b0);
        send_m(16'hF00F, 16'h0FF1, 1'b1);
        send_m(16'h8001, 16'h7FFF, 1'b0);
        send_m(16'hABCD, 16'h1234, 1'b1);
        in_a     = 16'h4444;
        in_b     = 16'h5555;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        pend     = model(16'h4444, 16'h5555, 1'b1);
        repeat (5) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(out_sum), 32'(q[0].sum));
            chk("stall_cout", 32'(out_cout), 32'(q[0].cout));
            cycle(acc, pop);
            chk("stall_no_accept", 32'(acc), 32'd0);
        end
        out_ready = 1'b1;
        cycle(acc, pop);
        chk("release_push", 32'(acc), 32'd1);
        chk("release_pop", 32'(pop), 32'd1);
        in_valid = 1'b0;
        repeat (4) begin
            cycle(acc, pop);
            chk("drain_rate", 32'(pop), 32'd1);
        end
        chk("stall_drain", 32'(q.size()), 32'd0);

        // Reset while a beat is in flight discards it
        send_m(16'h8000, 16'h8000, 1'b0);
        in_valid = 1'b0;
        repeat (2) cycle(acc, pop);
        rst = 1'b1;
        q.delete();
        repeat (2) begin
            #1;
            chk("rst_mid_valid", 32'(out_valid), 32'd0);
            cycle(acc, pop);
        end
        rst = 1'b0;
        repeat (8) begin
            #1;
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_ready", 32'(in_ready), 32'd1);
            cycle(acc, pop);
        end

`ifdef CLA_FLAGS_EN
        chk_lat = 1'b1;
        e.sum = 16'h8000; e.cout = 1'b0; e.zero = 1'b0; e.ovf = 1'b1;
        send(16'h7FFF, 16'h0001, 1'b0, e);
        e.sum = 16'h0000; e.cout = 1'b1; e.zero = 1'b1; e.ovf = 1'b1;
        send(16'h8000, 16'h8000, 1'b0, e);
        drain("drain_flags");
        chk_lat = 1'b0;
`endif

        // Random traffic with random source and sink stalls
        pending  = 1'b0;
        accepted = 0;
        ncyc     = 0;
        while (accepted < 10000 && ncyc < 60000) begin
            if (!pending && $urandom_range(0, 9) < 7) begin
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_cin   = 1'($urandom);
                in_valid = 1'b1;
                pend     = model(in_a, in_b, in_cin);
                pending  = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc, pop);
            if (acc) begin
                pending  = 1'b0;
                in_valid = 1'b0;
                accepted++;
            end
            ncyc++;
        end
        chk("rand_count", 32'(accepted), 32'd10000);
        drain("drain_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
